// File: rtl/ex_muldiv_if.sv
// Execute-stage M-extension request/response bundle.
// master = ID/EX + hazard side driving the op, slave = the mul/div engine.
`timescale 1ns/1ps
interface ex_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [4:0]       rd_i;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [4:0]       rd_o;
  logic             busy;

  modport master (
    output flush, start, op, a, b, rd_i,
    input  stall, done, result, rd_o, busy
  );

  modport slave (
    input  flush, start, op, a, b, rd_i,
    output stall, done, result, rd_o, busy
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide engine for the execute stage.
// One bit per cycle: shift-add multiply, restoring divide. Magnitudes are
// iterated and the sign is applied on the last iteration, so the result is
// registered on the same edge that enters DONE.
`timescale 1ns/1ps
module ex_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic         clk,
  input  logic         rst,
  ex_muldiv_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;

  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2:0]         op_q;
  logic [4:0]         rd_q;
  logic               neg_q;
  logic [WIDTH-1:0]   mcand_q;   // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_q;     // {hi, lo}: product, or {unused, dividend->quotient}
  logic [WIDTH:0]     rem_q;     // partial remainder
  logic               done_q;
  logic [WIDTH-1:0]   result_q;
  logic [4:0]         rd_o_q;
  logic               busy_q;

  // operand decode for a new request
  logic             is_div, a_sgn, b_sgn, a_neg, b_neg, neg_start;
  logic             div_zero, div_ovf, fast;
  logic [WIDTH-1:0] a_abs, b_abs, fast_res;

  // one iteration step
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_mul_nx;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH:0]     rem_nx;
  logic [WIDTH-1:0]   q_nx;

  // final sign fix-up
  logic [2*WIDTH-1:0] prod_f;
  logic [WIDTH-1:0]   mul_res, div_val, div_res, calc_res;
  logic               last_iter;

  // decode sign handling, fast-path cases and operand magnitudes
  always_comb begin
    is_div    = bus.op[2];
    a_sgn     = (bus.op == OP_MULH) || (bus.op == OP_MULHSU) || (is_div && !bus.op[0]);
    b_sgn     = (bus.op == OP_MULH) || (is_div && !bus.op[0]);
    a_neg     = a_sgn && bus.a[WIDTH-1];
    b_neg     = b_sgn && bus.b[WIDTH-1];
    a_abs     = a_neg ? -bus.a : bus.a;
    b_abs     = b_neg ? -bus.b : bus.b;
    // remainder follows the dividend; product and quotient follow a^b
    neg_start = (is_div && bus.op[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero  = is_div && (bus.b == '0);
    div_ovf   = is_div && !bus.op[0] && (bus.a == SMIN) && (bus.b == '1);
    fast      = div_zero || div_ovf;
    if (div_zero) fast_res = bus.op[1] ? bus.a : '1;
    else          fast_res = bus.op[1] ? '0 : SMIN;
  end

  // next-iteration datapath for both multiply and divide
  always_comb begin
    mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_mul_nx = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift  = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
    div_ge     = div_shift >= {1'b0, mcand_q};
    rem_nx     = div_ge ? (div_shift - {1'b0, mcand_q}) : div_shift;
    q_nx       = {acc_q[WIDTH-2:0], div_ge};
  end

  // result selection and sign fix-up, used on the final iteration
  always_comb begin
    prod_f    = neg_q ? -acc_mul_nx : acc_mul_nx;
    mul_res   = (op_q == OP_MUL) ? prod_f[WIDTH-1:0] : prod_f[2*WIDTH-1:WIDTH];
    div_val   = op_q[1] ? rem_nx[WIDTH-1:0] : q_nx;
    div_res   = neg_q ? -div_val : div_val;
    calc_res  = op_q[2] ? div_res : mul_res;
    last_iter = (cnt_q == CNT_W'(WIDTH-1));
  end

  // control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      rd_o_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.flush) begin
        // abort: result/rd_o keep their previous values
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.start) begin
              if (fast) begin
                state_q  <= DONE;
                done_q   <= 1'b1;
                result_q <= fast_res;
                rd_o_q   <= bus.rd_i;
              end else begin
                state_q <= CALC;
                busy_q  <= 1'b1;
                op_q    <= bus.op;
                rd_q    <= bus.rd_i;
                neg_q   <= neg_start;
                mcand_q <= b_abs;
                acc_q   <= {{WIDTH{1'b0}}, a_abs};
                rem_q   <= '0;
                cnt_q   <= '0;
              end
            end
          end
          CALC: begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (op_q[2]) begin
              acc_q <= {acc_q[2*WIDTH-1:WIDTH], q_nx};
              rem_q <= rem_nx;
            end else begin
              acc_q <= acc_mul_nx;
            end
            if (last_iter) begin
              state_q  <= DONE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              result_q <= calc_res;
              rd_o_q   <= rd_q;
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // hold IF/ID/EX while a request is being accepted or iterated
  always_comb begin
    bus.stall = !bus.flush && (((state_q == IDLE) && bus.start) || (state_q == CALC));
  end

  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.rd_o   = rd_o_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: driver pushes expected results from
// an arithmetic reference model, monitor pops on every done pulse.
`timescale 1ns/1ps
module tb_ex_muldiv_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_muldiv_if #(.WIDTH(32)) bus();
  ex_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          nvec = 0;
  int          nmis = 0;
  int          cyc  = 0;
  bit          pend = 0;
  logic [31:0] last_res = '0;
  logic [4:0]  last_rd  = '0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nmis++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // RV32M semantics computed with plain 64-bit / 32-bit arithmetic
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb2, ua, ub;
    logic [63:0] p;
    int          ia, ib;
    bit          ovf;
    sa = $signed(a); sb2 = $signed(b);
    ua = a; ub = b;
    ia = a; ib = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = ua * ub;  return p[31:0];  end
      3'd1: begin p = sa * sb2; return p[63:32]; end
      3'd2: begin p = sa * ub;  return p[63:32]; end
      3'd3: begin p = ua * ub;  return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && ((b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Present an op with start held until the stall drops (DONE cycle).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    exp_t e;
    int   t, n;
    bit   f;
    bus.op = op; bus.a = a; bus.b = b; bus.rd_i = rd;
    bus.start = 1'b1; bus.flush = 1'b0;
    if (pend) @(negedge clk);
    pend = 0;
    #1;
    t = cyc;
    f = is_fast(op, a, b);
    e.res = model(op, a, b);
    e.rd  = rd;
    e.due = t + (f ? 1 : 33);
    sb.push_back(e);
    n = 0;
    while (bus.stall === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk("stall_len", 32'(n), f ? 32'd1 : 32'd33);
    pend = 1;
  endtask

  task automatic go_idle();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    if (pend) @(negedge clk);
    pend = 0;
  endtask

  // monitor: every done pulse must match the oldest expectation
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        nvec++; nmis++;
        $display("FAIL spurious_done: got done=1 expected none (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("result", bus.result, e.res);
        chk("rd_o", 32'(bus.rd_o), 32'(e.rd));
        chk("done_cycle", 32'(cyc), 32'(e.due));
        last_res = e.res;
        last_rd  = e.rd;
      end
    end
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    int          k;
    bus.flush = 0; bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0; bus.rd_i = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_done",   32'(bus.done), 0);
    chk("rst_result", bus.result, 0);
    chk("rst_rd_o",   32'(bus.rd_o), 0);
    chk("rst_busy",   32'(bus.busy), 0);
    chk("rst_stall",  32'(bus.stall), 0);
    rst = 1'b0;
    @(negedge clk);

    // directed vectors, back-to-back with start held
    run_op(3'd0, 32'd7,          32'hFFFF_FFFD, 5'd3);
    run_op(3'd1, 32'h8000_0000,  32'h8000_0000, 5'd4);
    run_op(3'd3, 32'h8000_0000,  32'h8000_0000, 5'd5);
    run_op(3'd2, 32'hFFFF_FFFF,  32'd2,         5'd6);
    run_op(3'd4, 32'hFFFF_FFF9,  32'd2,         5'd7);
    run_op(3'd6, 32'hFFFF_FFF9,  32'd2,         5'd8);
    run_op(3'd5, 32'd100,        32'd7,         5'd9);
    run_op(3'd7, 32'd100,        32'd7,         5'd10);
    run_op(3'd5, 32'd5,          32'd0,         5'd11);
    run_op(3'd6, 32'd5,          32'd0,         5'd12);
    run_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd13);
    run_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd14);
    run_op(3'd0, 32'h1234_5678,  32'h9ABC_DEF0, 5'd15);
    run_op(3'd5, 32'hFFFF_FFFF,  32'd1,         5'd16);
    go_idle();
    repeat (2) @(negedge clk);

    // flush during CALC
    bus.op = 3'd0; bus.a = 32'd9; bus.b = 32'd9; bus.rd_i = 5'd20; bus.start = 1'b1;
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    #1;
    chk("flush_stall", 32'(bus.stall), 0);
    @(negedge clk);
    #1;
    chk("flush_busy",   32'(bus.busy), 0);
    chk("flush_done",   32'(bus.done), 0);
    chk("flush_result", bus.result, last_res);
    chk("flush_rd_o",   32'(bus.rd_o), 32'(last_rd));
    bus.flush = 1'b0; bus.start = 1'b0;
    repeat (40) @(negedge clk);

    // flush and start together in IDLE: nothing starts
    bus.op = 3'd5; bus.a = 32'd5; bus.b = 32'd0; bus.rd_i = 5'd21;
    bus.start = 1'b1; bus.flush = 1'b1;
    #1;
    chk("fs_stall", 32'(bus.stall), 0);
    @(negedge clk);
    #1;
    chk("fs_busy", 32'(bus.busy), 0);
    chk("fs_done", 32'(bus.done), 0);
    bus.start = 1'b0; bus.flush = 1'b0;
    repeat (3) @(negedge clk);

    // random ops with corner-case bias
    for (k = 0; k < 40; k++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
        3: b = $urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'h8000_0000;
        default: ;
      endcase
      run_op(op, a, b, 5'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        go_idle();
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    go_idle();
    repeat (2) @(negedge clk);

    // synchronous reset in the middle of an operation
    bus.op = 3'd5; bus.a = 32'd1000; bus.b = 32'd3; bus.rd_i = 5'd22; bus.start = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_rst_done",   32'(bus.done), 0);
    chk("mid_rst_result", bus.result, 0);
    chk("mid_rst_rd_o",   32'(bus.rd_o), 0);
    chk("mid_rst_busy",   32'(bus.busy), 0);
    rst = 1'b0; bus.start = 1'b0;
    last_res = '0; last_rd = '0;
    repeat (40) @(negedge clk);

    // one more op after reset to show recovery
    run_op(3'd7, 32'd1000, 32'd3, 5'd23);
    go_idle();
    repeat (5) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
